// File: rtl/smadd_arb_pkg.sv
// Shared types for the sign-magnitude adder arbiter.
// Defaults, response bundle and FIFO sizing helper.
package smadd_arb_pkg;

   localparam int SMADD_DW   = 4;
   localparam int SMADD_NREQ = 4;
   localparam int SMADD_IDW  = $clog2(SMADD_NREQ);

   typedef logic [SMADD_IDW-1:0] id_t;

   typedef struct packed {
      logic [SMADD_DW:0] sum;
      id_t               id;
   } rsp_t;

   // Room for the adder pipeline plus one slot of pop slack.
   function automatic int fifo_depth(input int lat);
      return lat + 2;
   endfunction

endpackage

// File: rtl/rom_based_sign_magnitude_adder.sv
// Sign-magnitude adder with a registered ROM read.
// LATENCY clocks from a/b stable to sum valid.
module rom_based_sign_magnitude_adder #(
   parameter int DATA_WIDTH = 4,
   parameter int LATENCY    = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH:0]   sum
);

   localparam int MW = DATA_WIDTH - 1;

   logic [DATA_WIDTH:0] stg [LATENCY];

   // ROM contents: equal magnitudes of opposite sign give +0.
   function automatic logic [DATA_WIDTH:0] rom(
      input logic [DATA_WIDTH-1:0] x,
      input logic [DATA_WIDTH-1:0] y
   );
      logic                  sx, sy;
      logic [DATA_WIDTH-1:0] mx, my;
      sx = x[DATA_WIDTH-1];
      sy = y[DATA_WIDTH-1];
      mx = {1'b0, x[MW-1:0]};
      my = {1'b0, y[MW-1:0]};
      if (sx == sy)    rom = {sx, mx + my};
      else if (mx > my) rom = {sx, mx - my};
      else if (my > mx) rom = {sy, my - mx};
      else              rom = '0;
   endfunction

   // Registered ROM read followed by any extra delay stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < LATENCY; k++) stg[k] <= '0;
      end else begin
         stg[0] <= rom(a, b);
         for (int k = 1; k < LATENCY; k++) stg[k] <= stg[k-1];
      end
   end

   assign sum = stg[LATENCY-1];

endmodule

// File: rtl/smadd_rsp_fifo.sv
// Response FIFO of rsp_t with occupancy count.
// Head reads as zero while empty.
module smadd_rsp_fifo
   import smadd_arb_pkg::*;
#(
   parameter int DEPTH = 3
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  rsp_t                       din,
   input  logic                       pop,
   output rsp_t                       dout,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   rsp_t          mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          do_pop;

   assign do_pop = pop & (count != '0);

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   // Storage, wrapping pointers and count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= nxt(wr_ptr);
         end
         if (do_pop) rd_ptr <= nxt(rd_ptr);
         if (push && !do_pop)      count <= count + 1'b1;
         else if (!push && do_pop) count <= count - 1'b1;
      end
   end

   assign dout = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/smadd_arbiter.sv
// N_REQ requesters sharing one ROM sign-magnitude adder.
// SMADD_ARB_RR_EN: round-robin grant; else fixed priority.
module smadd_arbiter
   import smadd_arb_pkg::*;
#(
   parameter int DATA_WIDTH    = SMADD_DW,
   parameter int N_REQ         = SMADD_NREQ,
   parameter int ADDER_LATENCY = 1
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [N_REQ-1:0]                   req_valid,
   input  logic [N_REQ-1:0][DATA_WIDTH-1:0]   req_a,
   input  logic [N_REQ-1:0][DATA_WIDTH-1:0]   req_b,
   output logic [N_REQ-1:0]                   req_ready,
   output logic                               rsp_valid,
   input  logic                               rsp_ready,
   output logic [DATA_WIDTH:0]                rsp_sum,
   output logic [$clog2(N_REQ)-1:0]           rsp_id
);

   localparam int DEPTH = fifo_depth(ADDER_LATENCY);
   localparam int CNTW  = $clog2(DEPTH+1);
   localparam int OCCW  = $clog2(2*DEPTH+1) + 1;

   logic [N_REQ-1:0]         grant;
   id_t                      gid;
   int                       sel;
   logic                     credit_ok, accept, pop;
   logic [OCCW-1:0]          occ;
   logic                     op_v;
   logic [DATA_WIDTH-1:0]    op_a, op_b;
   id_t                      op_id;
   logic [ADDER_LATENCY-1:0] pipe_v;
   id_t                      pipe_id [ADDER_LATENCY];
   logic [DATA_WIDTH:0]      add_sum;
   rsp_t                     fifo_in, fifo_out;
   logic [CNTW-1:0]          fifo_cnt;

`ifdef SMADD_ARB_RR_EN
   id_t ptr;

   // Search start moves past the winner, only on an accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      ptr <= '0;
      else if (accept) ptr <= (gid == id_t'(N_REQ-1)) ? '0 : gid + 1'b1;
   end
`else
   localparam id_t ptr = '0;
`endif

   // First valid requester at or after ptr wins.
   always_comb begin
      grant = '0;
      gid   = '0;
      sel   = 0;
      for (int k = N_REQ-1; k >= 0; k--) begin
         sel = (int'(ptr) + k) % N_REQ;
         if (req_valid[sel]) begin
            grant      = '0;
            grant[sel] = 1'b1;
            gid        = id_t'(sel);
         end
      end
   end

   // Slots committed: operand reg, shift pipe, FIFO, less this pop.
   always_comb begin
      occ = OCCW'(op_v) + OCCW'(fifo_cnt);
      for (int k = 0; k < ADDER_LATENCY; k++) occ = occ + OCCW'(pipe_v[k]);
      occ = occ - OCCW'(pop);
   end

   assign credit_ok = rst_n & (occ < OCCW'(DEPTH));
   assign req_ready = grant & {N_REQ{credit_ok}};
   assign accept    = |req_ready;
   assign rsp_valid = (fifo_cnt != '0);
   assign pop       = rsp_valid & rsp_ready;

   // Adder input register loaded from the granted requester.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_v  <= 1'b0;
         op_a  <= '0;
         op_b  <= '0;
         op_id <= '0;
      end else begin
         op_v <= accept;
         if (accept) begin
            op_a  <= req_a[gid];
            op_b  <= req_b[gid];
            op_id <= gid;
         end
      end
   end

   // Valid/id shadow of the adder's internal pipeline.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_v <= '0;
         for (int k = 0; k < ADDER_LATENCY; k++) pipe_id[k] <= '0;
      end else begin
         pipe_v[0]  <= op_v;
         pipe_id[0] <= op_id;
         for (int k = 1; k < ADDER_LATENCY; k++) begin
            pipe_v[k]  <= pipe_v[k-1];
            pipe_id[k] <= pipe_id[k-1];
         end
      end
   end

   rom_based_sign_magnitude_adder #(
      .DATA_WIDTH (DATA_WIDTH),
      .LATENCY    (ADDER_LATENCY)
   ) u_adder (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (op_a),
      .b     (op_b),
      .sum   (add_sum)
   );

   assign fifo_in = '{sum: add_sum, id: pipe_id[ADDER_LATENCY-1]};

   smadd_rsp_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (pipe_v[ADDER_LATENCY-1]),
      .din   (fifo_in),
      .pop   (pop),
      .dout  (fifo_out),
      .count (fifo_cnt)
   );

   assign rsp_sum = fifo_out.sum;
   assign rsp_id  = fifo_out.id;

endmodule

// File: tb/tb_smadd_arbiter.sv
// Directed bench for smadd_arbiter.
// Expected grant order follows SMADD_ARB_RR_EN.
module tb_smadd_arbiter;

   localparam int DW = 4;
   localparam int NR = 4;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [NR-1:0]          req_valid;
   logic [NR-1:0][DW-1:0]  req_a, req_b;
   logic [NR-1:0]          req_ready;
   logic                   rsp_valid, rsp_ready;
   logic [DW:0]            rsp_sum;
   logic [1:0]             rsp_id;

   int       nvec = 0;
   int       nerr = 0;
   int       nacc;
   logic [6:0] rq [$];

`ifdef SMADD_ARB_RR_EN
   int arb_exp [5] = '{0, 1, 2, 3, 0};
`else
   int arb_exp [5] = '{0, 0, 0, 0, 0};
`endif

   always #5 clk = ~clk;

   smadd_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_id    (rsp_id)
   );

   // Record every response popped at the coming edge.
   always begin
      @(negedge clk);
      #3;
      if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1)
         rq.push_back({rsp_id, rsp_sum});
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_rsp(input string tag, input int idx,
                          input logic [1:0] id, input logic [4:0] sum);
      check(tag, (idx < rq.size()) ? 32'(rq[idx]) : 32'hFFFF,
            32'({id, sum}));
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '1;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      #2;
      check("rst_ready", req_ready, 0);
      check("rst_valid", rsp_valid, 0);
      check("rst_sum", rsp_sum, 0);
      check("rst_id", rsp_id, 0);
      tick();
      req_valid = '0;
      tick();
      rst_n = 1'b1;
      tick();

      // single request from requester 0
      rq.delete();
      req_valid = 4'b0001;
      req_a[0]  = 4'b0100;
      req_b[0]  = 4'b0001;
      rsp_ready = 1'b1;
      #1;
      check("t1_ready", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      check("t1_lat1", rsp_valid, 0);
      tick();
      check("t1_lat2", rsp_valid, 0);
      tick();
      check("t1_valid", rsp_valid, 1);
      check("t1_sum", rsp_sum, 5'b00101);
      check("t1_id", rsp_id, 0);
      tick();
      check("t1_empty", rsp_valid, 0);
      check("t1_count", rq.size(), 1);

      // back-to-back from requester 2
      req_valid = 4'b0100;
      req_a[2]  = 4'b0100;
      req_b[2]  = 4'b1001;
      #1;
      check("t2_rdy0", req_ready, 4'b0100);
      tick();
      req_a[2] = 4'b1100;
      req_b[2] = 4'b0001;
      #1;
      check("t2_rdy1", req_ready, 4'b0100);
      tick();
      req_a[2] = 4'b1100;
      req_b[2] = 4'b1001;
      #1;
      check("t2_rdy2", req_ready, 4'b0100);
      tick();
      req_valid = '0;
      check("t2_sum0", {rsp_valid, rsp_id, rsp_sum}, {1'b1, 2'd2, 5'b00011});
      tick();
      check("t2_sum1", {rsp_valid, rsp_id, rsp_sum}, {1'b1, 2'd2, 5'b10011});
      tick();
      check("t2_sum2", {rsp_valid, rsp_id, rsp_sum}, {1'b1, 2'd2, 5'b10101});
      tick();
      check("t2_empty", rsp_valid, 0);

      // all four valid; pointer starts from reset
      do_reset();
      rq.delete();
      for (int i = 0; i < NR; i++) begin
         req_a[i] = DW'(i);
         req_b[i] = '0;
      end
      req_valid = '1;
      rsp_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         check($sformatf("arb%0d", k), req_ready, 32'(1) << arb_exp[k]);
         tick();
      end
      req_valid = '0;
      repeat (4) tick();
      check("arb_nrsp", rq.size(), 5);
      for (int k = 0; k < 5; k++)
         chk_rsp($sformatf("arb_rsp%0d", k), k, 2'(arb_exp[k]),
                 5'(arb_exp[k]));

      // backpressure with requester 1 streaming
      rq.delete();
      rsp_ready = 1'b0;
      nacc      = 0;
      req_a[1]  = 4'd1;
      req_b[1]  = 4'd0;
      req_valid = 4'b0010;
      for (int c = 0; c < 6; c++) begin
         #1;
         check($sformatf("bp_rdy%0d", c), req_ready,
               (c < 3) ? 4'b0010 : 4'b0000);
         if (req_ready[1]) nacc++;
         tick();
         req_a[1] = DW'(nacc + 1);
      end
      check("bp_nacc", nacc, 3);
      check("bp_head", {rsp_valid, rsp_id, rsp_sum}, {1'b1, 2'd1, 5'b00001});

      // full FIFO: a pop frees a credit for a same-cycle accept
      req_valid = 4'b1000;
      req_a[3]  = 4'b1000;
      req_b[3]  = 4'b1000;
      #1;
      check("full_stall", req_ready, 4'b0000);
      rsp_ready = 1'b1;
      #1;
      check("full_credit", req_ready, 4'b1000);
      tick();
      req_valid = '0;
      check("full_head", {rsp_valid, rsp_id, rsp_sum}, {1'b1, 2'd1, 5'b00010});
      repeat (6) tick();
      check("bp_nrsp", rq.size(), 4);
      chk_rsp("bp_rsp0", 0, 2'd1, 5'b00001);
      chk_rsp("bp_rsp1", 1, 2'd1, 5'b00010);
      chk_rsp("bp_rsp2", 2, 2'd1, 5'b00011);
      chk_rsp("nz_rsp", 3, 2'd3, 5'b10000);

      // asynchronous reset with two buffered results
      rq.delete();
      rsp_ready = 1'b0;
      req_valid = 4'b0001;
      req_a[0]  = 4'd1;
      req_b[0]  = 4'd1;
      tick();
      req_a[0] = 4'd2;
      tick();
      req_valid = '0;
      tick();
      tick();
      check("ar_pre", {rsp_valid, rsp_id, rsp_sum}, {1'b1, 2'd0, 5'b00010});
      rst_n = 1'b0;
      #1;
      check("ar_drop", rsp_valid, 0);
      check("ar_sum", rsp_sum, 0);
      tick();
      rst_n = 1'b1;
      #1;
      check("ar_empty", rsp_valid, 0);
      rsp_ready = 1'b1;
      req_valid = 4'b0001;
      req_a[0]  = 4'b0101;
      req_b[0]  = 4'b0010;
      tick();
      req_valid = '0;
      repeat (4) tick();
      check("ar_nrsp", rq.size(), 1);
      chk_rsp("ar_rsp0", 0, 2'd0, 5'b00111);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/smadd_arbiter.md
# smadd_arbiter

Shares one `rom_based_sign_magnitude_adder` instance between `N_REQ` requesters. Each requester gets a valid/ready request port. Responses come back on a single tagged response port with backpressure. The block does arbitration, operand registering and in-flight tracking across the adder's registered ROM read, and buffers results in a credit-protected response FIFO so no result is ever dropped. It sits between the client datapaths and the adder, and instantiates the adder internally.

## Interface
- `DATA_WIDTH`, 4: operand width, sign-magnitude, MSB is the sign.
- `N_REQ`, 4: number of requesters, ≥2.
- `ADDER_LATENCY`, 1: clocks from adder `a`/`b` stable to `sum` valid (registered ROM read).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_a`  in  N_REQ×DATA_WIDTH  operand a per requester.
- `req_b`  in  N_REQ×DATA_WIDTH  operand b per requester.
- `req_ready`  out  N_REQ  per-requester accept; at most one bit high.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_sum`  out  DATA_WIDTH+1  sign-magnitude sum from the adder.
- `rsp_id`  out  $clog2(N_REQ)  index of the originating requester.

## Operation
- **Grant:** combinational over `req_valid`. `req_ready[i] = grant[i] & credit_ok`. Acceptance on requester i is `req_valid[i] & req_ready[i]` at a rising edge.
- **Request rules:** a requester holds valid and its operands stable until accepted. `req_ready` may depend on `req_valid`.
- **Operand path:** accepted operands and id are registered into the adder input register. A valid/id shift pipe of depth `ADDER_LATENCY` tracks the operation alongside the adder.
- **Capture:** the adder output is not modified. `rsp_sum` is exactly the adder's `sum`, including its handling of negative zero.
- **Response FIFO:**
  - Depth `ADDER_LATENCY+2`, first-in first-out.
  - Responses emerge in acceptance order.
  - Pop on `rsp_valid & rsp_ready`.
- **Credits:**
  - `credit_ok = (inflight + fifo_count - pop) < DEPTH`.
  - `inflight` counts the operand register plus the shift pipe.
  - This guarantees the FIFO never overflows and sustains one operation per cycle when `rsp_ready` is held high.
- **No FSM beyond:** grant pointer, inflight pipe, FIFO pointers/count.
- **Boundaries:**
  - FIFO full with no pop: all `req_ready` low.
  - FIFO empty: `rsp_valid` low.
  - Simultaneous push and pop: count unchanged.
  - FIFO pointers wrap modulo DEPTH.
  - `rsp_ready` low for many cycles: results are held, operations stall, none are lost.
  - Reset mid-operation: all in-flight and buffered results are discarded.

## Timing
- **Reset values:**
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_sum` = 0, `rsp_id` = 0.
  - Round-robin pointer = 0, FIFO empty, inflight pipe cleared.
- **Latency:** a request accepted at edge t produces `rsp_valid` high from edge t+ADDER_LATENCY+1. With the default this is 2 clocks.
- **Throughput:** 1 accept per clock while `rsp_ready` = 1 and some `req_valid` is high.
- **Pointer update:** the grant pointer updates only on an accepted request, never on a stall.

## Configuration
- **`SMADD_ARB_RR_EN` defined:** round-robin arbitration. Search starts at the index after the last accepted requester. Every continuously valid requester is served within `N_REQ` accepts.
- **`SMADD_ARB_RR_EN` undefined:** fixed priority, lowest index wins. The pointer logic is not built.

## Structure
- **Package `smadd_arb_pkg`:**
  - Default `DATA_WIDTH` and `N_REQ`.
  - `id_t` typedef.
  - `rsp_t` struct {sum, id}.
  - Function computing FIFO depth from `ADDER_LATENCY`.
- **Sub-module `smadd_rsp_fifo`:** parameterised synchronous FIFO of `rsp_t` with count output. Top-level instantiates it and the adder.

## Test plan
- **Single request:**
  - Stimulus: requester 0 only, a=4'b0100, b=4'b0001, `rsp_ready`=1.
  - Response: `rsp_sum`=5'b00101, `rsp_id`=0, two clocks after accept.
- **Back-to-back from requester 2:**
  - Stimulus: (0100,1001), then (1100,0001), then (1100,1001).
  - Response: 00011, 10011, 10101 on consecutive cycles, `rsp_id`=2, in order.
- **Arbitration with all four valid:**
  - Stimulus: all four valid continuously.
  - With `SMADD_ARB_RR_EN`: accept order 0,1,2,3,0.
  - Without it: 0 repeatedly.
- **Backpressure:**
  - Stimulus: `rsp_ready`=0 with requester 1 streaming.
  - Response: exactly DEPTH=3 accepts, then `req_ready` all 0.
  - Then raise `rsp_ready`: 3 responses drain in order, none lost or duplicated.
- **Async reset:**
  - Stimulus: assert `rst_n`=0 mid-stream with 2 results buffered.
  - Response: `rsp_valid` drops immediately without waiting for a clock edge.
  - After release: FIFO empty, first response corresponds to the first post-reset accept.
- **Simultaneous push and pop with a full FIFO:**
  - Stimulus: FIFO at DEPTH, `rsp_ready`=1 and a new request valid.
  - Response: accept allowed via pop credit, count stays constant.
